// File: rtl/booth_r4_seq_mult.sv
// Iterative W x W signed multiplier using radix-4 (modified Booth) recoding.
// It retires two multiplier bits per clock through one shared add/subtract path.
module booth_r4_seq_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [1:0]     state_dbg
);

    // Handshake: start is sampled only in IDLE; the operands are captured on that
    // same edge. busy is high for every non-IDLE cycle. done pulses for the single
    // DONE cycle, and product takes its new value on the edge that ends that cycle.

    localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [W+1:0] a;
    logic [W-1:0] qr;
    logic         q_m1;
    logic [W-1:0] mr;
    logic [CW-1:0] cnt;

    logic [W+1:0] m_ext, m2, addend, sum;
    logic         sub;
    logic [W+1:0] a_nx;
    logic [W-1:0] qr_nx;
    logic         last_step;

    assign last_step = (cnt == CW'(W / 2 - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Booth digit select. A subtraction adds the inverted operand with carry-in 1.
    always_comb begin
        m_ext  = {{2{mr[W-1]}}, mr};
        m2     = {m_ext[W:0], 1'b0};
        addend = '0;
        sub    = 1'b0;
        case ({qr[1:0], q_m1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m2;
            3'b100:         begin addend = m2;    sub = 1'b1; end
            3'b101, 3'b110: begin addend = m_ext; sub = 1'b1; end
            default:        addend = '0;
        endcase
        sum   = a + (sub ? ~addend : addend) + {{(W+1){1'b0}}, sub};
        a_nx  = {{2{sum[W+1]}}, sum[W+1:2]};
        qr_nx = {sum[1:0], qr[W-1:2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            qr      <= '0;
            q_m1    <= 1'b0;
            mr      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mr   <= multiplicand;
                        qr   <= multiplier;
                        a    <= '0;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a    <= a_nx;
                    qr   <= qr_nx;
                    q_m1 <= qr[1];
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    product <= {a[W-1:0], qr};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/booth_r4_seq_mult.md
# booth_r4_seq_mult

Iterative signed multiplier. It performs a W×W two's-complement multiply using radix-4 (modified Booth) recoding, retiring two multiplier bits per clock through a single shared add/subtract path. It sits beside the combinational radix-4 multiplier in the arithmetic library as the area-lean, multi-cycle alternative. It uses a start/busy/done handshake so a host sequencer can issue one operation at a time.

## Interface
- W, 8, operand width; must be even and ≥ 4.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  W  signed operand M; captured on the accepting edge.
- multiplier  in  W  signed operand Q; captured on the accepting edge.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- product  out  2W  signed result; registered, held until the next completion.

## Operation
- Reset is asynchronous and active-low, using one clock. On rst_n low:
  - state = IDLE.
  - busy = 0, done = 0, product = 0.
  - All internal registers clear.
- Internal registers:
  - A: W+2 bits, signed accumulator.
  - Qr: W bits, shifting multiplier.
  - q_m1: 1 bit, the implicit Q[-1].
  - Mr: W bits, captured multiplicand.
  - cnt: counts W/2 iterations.
- States:
  - IDLE: if start=1, load Mr=multiplicand, Qr=multiplier, A=0, q_m1=0, cnt=0, then go to RUN. Otherwise stay.
  - RUN: one Booth step per clock. After the step where cnt reaches W/2-1, go to DONE.
  - DONE: load product, then go to IDLE unconditionally.
- Booth step, taking {Qr[1], Qr[0], q_m1}:
  - 000 or 111 → +0.
  - 001 or 010 → +M.
  - 011 → +2M.
  - 100 → −2M.
  - 101 or 110 → −M.
- Arithmetic rules:
  - M is sign-extended to W+2 bits. 2M is M shifted left by 1 in W+2 bits.
  - Subtraction is done as an add of the inverted operand with carry-in 1.
  - The sum is computed modulo 2^(W+2); there is no overflow in this width.
  - Then {A, Qr, q_m1} shifts arithmetically right by 2, with A's sign bit replicated.
- Result: after W/2 steps, product = {A[W-1:0], Qr}. This equals the exact signed product for every operand pair, including −2^(W-1) × −2^(W-1).
- start is ignored in RUN and DONE. There is no queueing, and operands are not re-sampled.
- Asserting rst_n mid-operation aborts the operation. After release the block is in IDLE with product = 0.

## Timing
- Let start be sampled high in IDLE at edge k.
  - Steps execute on edges k+1 through k+W/2.
  - The state enters DONE after edge k+W/2.
  - product updates and the state returns to IDLE on edge k+W/2+1.
- done is high for exactly one cycle, between edges k+W/2 and k+W/2+1.
- busy is high from after edge k until edge k+W/2+1, i.e. W/2+1 cycles.
- product takes its new value at edge k+W/2+1. The host samples it on or after that edge.
- Throughput: a new start can be accepted at edge k+W/2+2 at the earliest. Minimum issue interval is W/2+2 cycles (6 for W=8).
- Operand inputs need only be valid at the accepting edge. Changes afterwards have no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use W=8.
- Reset: hold rst_n=0 for 3 cycles, then release. Require busy=0, done=0, product=0, and state IDLE.
- Basic multiply: 7 × 3 and −5 × 6. Require product = 21 and then −30. done pulses exactly once, one cycle after the 4th step edge. busy is high for 5 cycles. product is updated on the edge that ends the done cycle.
- Extremes:
  - −128 × −128 → 16384.
  - −128 × 127 → −16256.
  - 127 × 127 → 16129.
  - 0 × −1 → 0.
  - −1 × −1 → 1.
  Also run 500 random signed pairs against a reference model; all must match.
- Start while busy: assert start=1 continuously with new operands during RUN and DONE. Require the result to reflect only the first operands. A second operation is accepted on the first IDLE cycle; done never pulses twice within 6 cycles.
- Reset mid-run: assert rst_n=0 asynchronously during step 2 of 9 × 9. Require busy and done to drop immediately and product = 0. A following 2 × 2 must yield 4 with normal latency.
